fir4_inv_dec: RTL and testbench

FIR4_INV_DEC -- requirements
Module: fir4_inv_dec

---
 rtl/fir4_pkg.sv | 27 ++
 rtl/fir4_inv_dec_if.sv | 48 ++++
 rtl/fir4_hist.sv | 69 ++++++
 rtl/fir4_inv_dec.sv | 114 +++++++++++
 tb/tb_fir4_inv_dec.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fir4_pkg.sv
// fir4_pkg -- shared definitions for the 4-tap moving-sum inverse decoder.
//
// Contents:
//   state_t      : decoder FSM state (RUN, ERR)
//   SUM_EXTRA    : extra bits of the incoming 4-tap sum over the sample width
//   DIFF_EXTRA   : extra bits of the signed difference over the sample width
//   sum_width()  : width of s_in / y_prev for a sample width w  (w+2)
//   diff_width() : width of the untruncated difference d         (w+3)
package fir4_pkg;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    localparam int SUM_EXTRA  = 2;
    localparam int DIFF_EXTRA = 3;

    function automatic int sum_width(input int w);
        return w + SUM_EXTRA;
    endfunction

    function automatic int diff_width(input int w);
        return w + DIFF_EXTRA;
    endfunction

endpackage

// File: rtl/fir4_inv_dec_if.sv
// fir4_inv_dec_if -- sample stream bundle for fir4_inv_dec.
//
// Signals:
//   in_valid  : producer has a 4-tap sum on s_in
//   in_ready  : decoder accepts s_in this cycle
//   s_in      : unsigned 4-tap moving sum, w+2 bits
//   out_valid : a_out holds a recovered sample
//   out_ready : consumer takes a_out this cycle
//   a_out     : recovered sample, w bits
//   err       : sticky range error flag
// Modports:
//   slave  : the decoder side
//   master : the side driving the stream and consuming results
interface fir4_inv_dec_if
    import fir4_pkg::*;
#(
    parameter int w = 16
);

    logic                      in_valid;
    logic                      in_ready;
    logic [sum_width(w)-1:0]   s_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [w-1:0]              a_out;
    logic                      err;

    modport slave (
        input  in_valid,
        input  s_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output a_out,
        output err
    );

    modport master (
        output in_valid,
        output s_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  a_out,
        input  err
    );

endinterface

// File: rtl/fir4_hist.sv
// fir4_hist -- history storage for the inverse decoder.
//
// Holds the previous 4-tap sum (y_prev) and a 4-deep shift register of
// recovered samples. On load, y_prev takes y_in and the recovered sample
// a_in enters at depth 1 while older samples move one step deeper.
// reset and clr both zero everything.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear of the history
//   load       : update enable (one accepted sample)
//   y_in       : sum being accepted, w+2 bits
//   a_in       : recovered sample being accepted, w bits
//   y_prev     : previous accepted sum
//   a_d4       : recovered sample four acceptances ago
module fir4_hist
    import fir4_pkg::*;
#(
    parameter int w = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    load,
    input  logic [sum_width(w)-1:0] y_in,
    input  logic [w-1:0]            a_in,
    output logic [sum_width(w)-1:0] y_prev,
    output logic [w-1:0]            a_d4
);

    localparam int DEPTH = 4;

    logic [sum_width(w)-1:0] y_prev_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            y_prev_reg <= '0;
        end else if (load) begin
            y_prev_reg <= y_in;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [w-1:0] tap_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset || clr) begin
                        tap_reg <= '0;
                    end else if (load) begin
                        tap_reg <= a_in;
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (reset || clr) begin
                        tap_reg <= '0;
                    end else if (load) begin
                        tap_reg <= g_tap[gi-1].tap_reg;
                    end
                end
            end
        end
    endgenerate

    assign y_prev = y_prev_reg;
    assign a_d4   = g_tap[DEPTH-1].tap_reg;

endmodule

// File: rtl/fir4_inv_dec.sv
// fir4_inv_dec -- inverse of a unit-coefficient 4-tap moving sum.
//
// Given y[n] = a[n]+a[n-1]+a[n-2]+a[n-3], recovers
// a[n] = y[n] - y[n-1] + a[n-4] with a one-deep output register
// (latency 1, full throughput under valid/ready handshakes).
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (highest priority)
//   clr   : synchronous restart, clears history and error state
//   bus   : fir4_inv_dec_if.slave stream bundle (see interface file)
//
// Configuration macro FIR4INV_CHK_EN:
//   defined   : range check enabled; an out-of-range difference sends the
//               FSM to ERR, raising err and blocking input until clr/reset.
//   undefined : no FSM, err tied 0, out-of-range results wrap modulo 2^w.
module fir4_inv_dec
    import fir4_pkg::*;
#(
    parameter int w = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    fir4_inv_dec_if.slave bus
);

    localparam int SW = sum_width(w);
    localparam int DW = diff_width(w);

    logic [SW-1:0] y_prev;
    logic [w-1:0]  a_d4;
    logic [DW-1:0] d;
    logic          run_ok;
    logic          in_ready;
    logic          accept;

    logic          out_valid_reg;
    logic [w-1:0]  a_out_reg;

    // The difference is formed at w+3 bits so that neither a negative result
    // nor one above 2^w-1 can alias into the legal range [0, 2^w-1].
    assign d = {1'b0, bus.s_in} - {1'b0, y_prev} + {{(DW-w){1'b0}}, a_d4};

    assign in_ready = run_ok && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready && !clr;

    fir4_hist #(.w(w)) u_hist (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .load   (accept),
        .y_in   (bus.s_in),
        .a_in   (d[w-1:0]),
        .y_prev (y_prev),
        .a_d4   (a_d4)
    );

    // Output register: load on acceptance, drain on consume, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            a_out_reg     <= '0;
        end else if (clr) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            a_out_reg     <= d[w-1:0];
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef FIR4INV_CHK_EN
    state_t state_reg;
    state_t state_next;
    logic   out_of_range;

    // Any bit at or above w set means d is negative or exceeds 2^w-1.
    assign out_of_range = (d[DW-1:w] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = RUN;
        end else if (accept && out_of_range) begin
            state_next = ERR;
        end
    end

    assign run_ok  = (state_reg == RUN);
    assign bus.err = (state_reg == ERR);
`else
    // Upper difference bits only matter for the range check.
    logic unused_d_upper;
    assign unused_d_upper = ^d[DW-1:w];

    assign run_ok  = 1'b1;
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.a_out     = a_out_reg;

endmodule

// File: tb/tb_fir4_inv_dec.sv
// tb_fir4_inv_dec -- self-checking bench for fir4_inv_dec (w = 16).
//
// A behavioural model (integer arithmetic on a queue of recovered samples)
// is advanced once per cycle from the inputs that will be sampled at the
// next rising edge; a single compare process checks the DUT against it on
// every falling edge. Directed sequences add literal expectations, then a
// randomized phase mixes coherent sums, junk sums, stalls, clr and reset.
// Honours FIR4INV_CHK_EN the same way the design does.
module tb_fir4_inv_dec;

    localparam int W    = 16;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic clr;

    fir4_inv_dec_if #(.w(W)) bus ();

    fir4_inv_dec #(.w(W)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_init = 1'b0;
    bit           m_ov   = 1'b0;
    bit           m_err  = 1'b0;
    logic [W-1:0] m_a    = '0;
    int           m_yprev = 0;
    int           m_hist[$] = '{0, 0, 0, 0};   // [0] = newest recovered sample

    always @(negedge clk) begin
        bit rdy;
        int d;
        if (m_init) begin
            chk("out_valid", bus.out_valid, m_ov);
            chk("err", bus.err, m_err);
            chk("in_ready", bus.in_ready, (!m_err && (!m_ov || bus.out_ready)));
            if (m_ov) chk("a_out", bus.a_out, m_a);
        end
        if (reset) begin
            m_init  = 1'b1;
            m_ov    = 1'b0;
            m_err   = 1'b0;
            m_a     = '0;
            m_yprev = 0;
            m_hist  = '{0, 0, 0, 0};
        end else if (clr) begin
            m_ov    = 1'b0;
            m_err   = 1'b0;
            m_yprev = 0;
            m_hist  = '{0, 0, 0, 0};
        end else begin
            rdy = !m_err && (!m_ov || bus.out_ready);
            if (bus.in_valid && rdy) begin
                d = int'(bus.s_in) - m_yprev + m_hist[3];
                m_a = d[W-1:0];
                m_ov = 1'b1;
`ifdef FIR4INV_CHK_EN
                if (d < 0 || d > MAXV) m_err = 1'b1;
`endif
                m_yprev = int'(bus.s_in);
                m_hist.push_front(int'(m_a));
                void'(m_hist.pop_back());
                $display("txn s_in=%0d d=%0d a=%0d", bus.s_in, d, m_a);
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs, then return 2 time units after the edge.
    task automatic cyc(input bit v, input int s, input bit ordy, input bit c, input bit r);
        bus.in_valid  = v;
        bus.s_in      = s[W+1:0];
        bus.out_ready = ordy;
        clr           = c;
        reset         = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int dir_in[5];
        int dir_out[5];
        int s;
        int sel;
        bit rv, rc, ro, vv;

        dir_in  = '{5, 12, 21, 32, 27};
        dir_out = '{5, 7, 9, 11, 0};

        bus.in_valid  = 1'b0;
        bus.s_in      = '0;
        bus.out_ready = 1'b1;
        clr           = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #2;

        // Reset state
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_a_out", bus.a_out, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Basic decode with latency 1
        for (int i = 0; i < 5; i++) begin
            cyc(1, dir_in[i], 1, 0, 0);
            chk("basic_valid", bus.out_valid, 1);
            chk("basic_a_out", bus.a_out, dir_out[i]);
        end

        // Full-scale samples
        cyc(0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, i * MAXV, 1, 0, 0);
            chk("full_a_out", bus.a_out, MAXV);
        end
        chk("full_err", bus.err, 0);

        // Negative difference
        cyc(0, 0, 1, 1, 0);
        cyc(1, 3, 1, 0, 0);
        chk("neg_first", bus.a_out, 3);
        cyc(1, 1, 1, 0, 0);
        chk("neg_a_out", bus.a_out, 16'hFFFE);
        chk("neg_valid", bus.out_valid, 1);
`ifdef FIR4INV_CHK_EN
        chk("neg_err", bus.err, 1);
        chk("neg_in_ready", bus.in_ready, 0);
        cyc(1, 5, 1, 0, 0);
        chk("err_sticky", bus.err, 1);
`else
        chk("neg_err", bus.err, 0);
        chk("neg_in_ready", bus.in_ready, 1);
`endif

        // clr recovers, history cleared
        cyc(0, 0, 1, 1, 0);
        chk("clr_err", bus.err, 0);
        chk("clr_valid", bus.out_valid, 0);
        cyc(1, 8, 1, 0, 0);
        chk("clr_decode", bus.a_out, 8);

        // Back-pressure
        cyc(0, 0, 1, 1, 0);
        cyc(1, 10, 0, 0, 0);
        chk("bp_first", bus.a_out, 10);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 25, 0, 0, 0);
            chk("bp_hold", bus.a_out, 10);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        cyc(1, 25, 1, 0, 0);
        chk("bp_next", bus.a_out, 15);
        cyc(0, 0, 1, 0, 0);
        chk("bp_drain", bus.out_valid, 0);

        // reset and clr together with a pending output
        cyc(0, 0, 1, 1, 0);
        cyc(1, 7, 0, 0, 0);
        chk("rc_pending", bus.out_valid, 1);
        cyc(1, 9, 0, 1, 1);
        chk("rc_valid", bus.out_valid, 0);
        chk("rc_a_out", bus.a_out, 0);
        chk("rc_err", bus.err, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 80) begin
                s = m_hist[0] + m_hist[1] + m_hist[2] + $urandom_range(0, MAXV);
            end else if (sel < 90) begin
                s = $urandom_range(0, 40);
            end else begin
                s = $urandom_range(0, (1 << (W + 2)) - 1);
            end
            vv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 299) == 0);
            cyc(vv, s, ro, rc, rv);
        end

        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
